// File: rtl/emu_run_controller_if.sv
// Host command channel for the emulator run controller: valid/ready handshake
// carrying an opcode and a time/step argument.
interface emu_run_controller_if #(
  parameter int unsigned time_width = 64
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [time_width-1:0] cmd_arg;

  // Host side drives the command, controller answers with ready.
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );

endinterface

// File: rtl/emu_run_controller.sv
// Run/stop sequencer for the emulator time base. Contributes dt_cap to the
// time-step min-reduction: 0 freezes time, DMAX leaves it free, and in
// RUN_UNTIL it clamps so emulation time lands exactly on the target.
module emu_run_controller #(
  parameter int unsigned width      = 32,
  parameter int unsigned time_width = 64,
  parameter int unsigned step_width = 16
) (
  input  logic                         emu_clk,
  input  logic                         emu_rst_n,
  emu_run_controller_if.slave          cmd,
  input  logic                         ext_hold,
  input  logic signed [time_width-1:0] emu_time,
  input  logic signed [width-1:0]      emu_dt,
  output logic signed [width-1:0]      dt_cap,
  output logic                         emu_stall,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   state
);

  localparam int unsigned wide_w = time_width + 1;

  localparam logic [1:0] op_stop      = 2'd0;
  localparam logic [1:0] op_run       = 2'd1;
  localparam logic [1:0] op_run_until = 2'd2;
  localparam logic [1:0] op_step      = 2'd3;

  localparam logic signed [width-1:0]  dmax      = {1'b0, {(width-1){1'b1}}};
  localparam logic signed [wide_w-1:0] dmax_wide =
    {{(wide_w-width){1'b0}}, 1'b0, {(width-1){1'b1}}};

  typedef enum logic [1:0] {
    s_idle      = 2'd0,
    s_run_free  = 2'd1,
    s_run_until = 2'd2,
    s_step      = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic signed [time_width-1:0]  target_q, target_d;
  logic [step_width-1:0]         step_cnt_q, step_cnt_d;
  logic                          done_q, done_d;

  logic signed [wide_w-1:0]      time_wide;
  logic signed [wide_w-1:0]      target_wide;
  logic signed [wide_w-1:0]      dt_wide;
  logic signed [wide_w-1:0]      rem_c;
  logic signed [wide_w-1:0]      reach_sum_c;
  logic                          rem_pos_c;
  logic                          advance_c;
  logic                          reached_c;
  logic                          accept_c;
  logic                          arg_le_time_c;

  // One-bit-wider operands so target - time cannot wrap at the time extremes.
  assign time_wide   = {emu_time[time_width-1], emu_time};
  assign target_wide = {target_q[time_width-1], target_q};
  assign dt_wide     = {{(wide_w-width){emu_dt[width-1]}}, emu_dt};
  assign rem_c       = target_wide - time_wide;
  assign reach_sum_c = time_wide + dt_wide;
  assign rem_pos_c   = !rem_c[wide_w-1] && (rem_c != '0);
  assign reached_c   = reach_sum_c >= target_wide;

  // Only a strictly positive selected dt counts as progress; a hold never does.
  assign advance_c   = !ext_hold && !emu_dt[width-1] && (emu_dt != '0);

  assign arg_le_time_c = $signed(cmd.cmd_arg) <= emu_time;

  // Non-STOP commands back-pressure until the controller is idle.
  assign cmd.cmd_ready = (state_q == s_idle) || (cmd.cmd_op == op_stop);
  assign accept_c      = cmd.cmd_valid && cmd.cmd_ready;

  // dt request straight from registered state so no latency enters the time path.
  always_comb begin
    dt_cap = '0;
    if (!ext_hold) begin
      case (state_q)
        s_run_free, s_step: dt_cap = dmax;
        s_run_until: begin
          if (rem_pos_c) begin
            dt_cap = (rem_c > dmax_wide) ? dmax : rem_c[width-1:0];
          end
        end
        default: dt_cap = '0;
      endcase
    end
  end

  assign emu_stall = (dt_cap == '0);
  assign busy      = (state_q != s_idle);
  assign state     = state_q;
  assign done      = done_q;

  // Next-state logic; an accepted STOP overrides any same-cycle completion.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    step_cnt_d = step_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      s_idle: begin
        if (accept_c) begin
          case (cmd.cmd_op)
            op_stop: done_d = 1'b1;
            op_run:  state_d = s_run_free;
            op_run_until: begin
              target_d = $signed(cmd.cmd_arg);
              if (arg_le_time_c) begin
                done_d = 1'b1;
              end else begin
                state_d = s_run_until;
              end
            end
            op_step: begin
              step_cnt_d = cmd.cmd_arg[step_width-1:0];
              if (cmd.cmd_arg[step_width-1:0] == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = s_step;
              end
            end
            default: state_d = s_idle;
          endcase
        end
      end
      s_run_free: begin
        if (accept_c) begin
          state_d = s_idle;
          done_d  = 1'b1;
        end
      end
      s_run_until: begin
        if (accept_c || (advance_c && reached_c)) begin
          state_d = s_idle;
          done_d  = 1'b1;
        end
      end
      s_step: begin
        if (accept_c) begin
          state_d = s_idle;
          done_d  = 1'b1;
        end else if (advance_c) begin
          step_cnt_d = step_cnt_q - step_width'(1);
          if (step_cnt_q == step_width'(1)) begin
            state_d = s_idle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = s_idle;
    endcase
  end

  // State registers; reset aborts any run without a done pulse.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q    <= s_idle;
      target_q   <= '0;
      step_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      step_cnt_q <= step_cnt_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_emu_run_controller.sv
// Directed bench for emu_run_controller: a 32-bit instance inside a small
// time-base model (min of dt_cap and one fixed requester), plus an 8-bit
// instance for dt saturation.
module tb_emu_run_controller;

  localparam logic [63:0] dmax32 = 64'h7FFF_FFFF;

  logic emu_clk   = 1'b0;
  logic emu_rst_n = 1'b0;

  always #5 emu_clk = ~emu_clk;

  emu_run_controller_if #(.time_width(64)) cmd_if ();
  emu_run_controller_if #(.time_width(64)) cmd8_if ();

  logic               ext_hold;
  logic signed [63:0] emu_time;
  logic signed [31:0] emu_dt;
  logic signed [31:0] dt_cap;
  logic signed [31:0] other_dt;
  logic               emu_stall, busy, done;
  logic [1:0]         state;
  logic               load_en;
  logic signed [63:0] load_val;

  logic               ext_hold8;
  logic signed [63:0] emu_time8;
  logic signed [7:0]  emu_dt8;
  logic signed [7:0]  dt_cap8;
  logic               emu_stall8, busy8, done8;
  logic [1:0]         state8;

  int n_checks = 0;
  int n_errors = 0;

  emu_run_controller #(.width(32), .time_width(64), .step_width(16)) dut (
    .emu_clk   (emu_clk),
    .emu_rst_n (emu_rst_n),
    .cmd       (cmd_if),
    .ext_hold  (ext_hold),
    .emu_time  (emu_time),
    .emu_dt    (emu_dt),
    .dt_cap    (dt_cap),
    .emu_stall (emu_stall),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  emu_run_controller #(.width(8), .time_width(64), .step_width(16)) dut8 (
    .emu_clk   (emu_clk),
    .emu_rst_n (emu_rst_n),
    .cmd       (cmd8_if),
    .ext_hold  (ext_hold8),
    .emu_time  (emu_time8),
    .emu_dt    (emu_dt8),
    .dt_cap    (dt_cap8),
    .emu_stall (emu_stall8),
    .busy      (busy8),
    .done      (done8),
    .state     (state8)
  );

  // Time-base model: selected dt is the min of all requests.
  always_comb emu_dt = (dt_cap < other_dt) ? dt_cap : other_dt;
  always_comb emu_dt8 = dt_cap8;

  always @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      emu_time  <= '0;
      emu_time8 <= '0;
    end else begin
      emu_time  <= load_en ? load_val : emu_time + 64'(emu_dt);
      emu_time8 <= emu_time8 + 64'(emu_dt8);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge emu_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [63:0] arg);
    int guard;
    guard = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    #1;
    while (!cmd_if.cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!cmd_if.cmd_ready) check("cmd_accept_timeout", 64'(cmd_if.cmd_ready), 64'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic send_cmd8(input logic [1:0] op, input logic [63:0] arg);
    cmd8_if.cmd_valid = 1'b1;
    cmd8_if.cmd_op    = op;
    cmd8_if.cmd_arg   = arg;
    #1;
    check("w8_ready", 64'(cmd8_if.cmd_ready), 64'd1);
    tick();
    cmd8_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [63:0] t0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_op     = 2'd0;
    cmd_if.cmd_arg    = '0;
    cmd8_if.cmd_valid = 1'b0;
    cmd8_if.cmd_op    = 2'd0;
    cmd8_if.cmd_arg   = '0;
    ext_hold  = 1'b0;
    ext_hold8 = 1'b0;
    other_dt  = 32'sd7;
    load_en   = 1'b0;
    load_val  = '0;

    // Reset state
    repeat (3) tick();
    check("rst_state",  64'(state), 64'd0);
    check("rst_dt_cap", 64'(dt_cap), 64'd0);
    check("rst_stall",  64'(emu_stall), 64'd1);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_done",   64'(done), 64'd0);
    check("rst_ready",  64'(cmd_if.cmd_ready), 64'd1);
    emu_rst_n = 1'b1;
    tick();
    check("post_rst_state", 64'(state), 64'd0);
    check("post_rst_done",  64'(done), 64'd0);
    check("post_rst_time",  64'(emu_time), 64'd0);

    // STOP while idle pulses done
    send_cmd(2'd0, 64'd0);
    check("idle_stop_done",  64'(done), 64'd1);
    check("idle_stop_state", 64'(state), 64'd0);
    tick();
    check("idle_stop_done_clr", 64'(done), 64'd0);

    // STEP 0 completes immediately
    send_cmd(2'd3, 64'd0);
    check("step0_done",  64'(done), 64'd1);
    check("step0_state", 64'(state), 64'd0);
    tick();

    // RUN_UNTIL 30 with the other requester fixed at 7
    send_cmd(2'd2, 64'd30);
    for (int i = 0; i < 5; i++) begin
      logic [63:0] exp_cap;
      logic [63:0] exp_dt;
      exp_cap = 64'(30 - 7 * i);
      exp_dt  = (i == 4) ? 64'd2 : 64'd7;
      check($sformatf("ru_cap%0d", i), 64'(dt_cap), exp_cap);
      check($sformatf("ru_dt%0d", i), 64'(emu_dt), exp_dt);
      check($sformatf("ru_state%0d", i), 64'(state), 64'd2);
      check($sformatf("ru_done%0d", i), 64'(done), 64'd0);
      tick();
    end
    check("ru_end_time",  64'(emu_time), 64'd30);
    check("ru_end_done",  64'(done), 64'd1);
    check("ru_end_state", 64'(state), 64'd0);
    check("ru_end_cap",   64'(dt_cap), 64'd0);
    tick();
    check("ru_done_clr", 64'(done), 64'd0);
    check("ru_time_hold", 64'(emu_time), 64'd30);

    // RUN_UNTIL a target already in the past
    load_en  = 1'b1;
    load_val = 64'sd10;
    tick();
    load_en = 1'b0;
    check("past_load", 64'(emu_time), 64'd10);
    send_cmd(2'd2, 64'd5);
    check("past_done",  64'(done), 64'd1);
    check("past_state", 64'(state), 64'd0);
    check("past_cap",   64'(dt_cap), 64'd0);
    tick();
    check("past_done_clr", 64'(done), 64'd0);

    // STOP coincides with RUN_UNTIL completion: one done pulse
    load_en  = 1'b1;
    load_val = 64'sd100;
    tick();
    load_en = 1'b0;
    send_cmd(2'd2, 64'd107);
    check("race_cap", 64'(dt_cap), 64'd7);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'd0;
    #1;
    check("race_ready", 64'(cmd_if.cmd_ready), 64'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("race_done",  64'(done), 64'd1);
    check("race_state", 64'(state), 64'd0);
    check("race_time",  64'(emu_time), 64'd107);
    tick();
    check("race_done_clr", 64'(done), 64'd0);

    // STEP 3 with a hold on the second active cycle
    send_cmd(2'd3, 64'd3);
    t0 = emu_time;
    for (int i = 0; i < 4; i++) begin
      ext_hold = (i == 1);
      #1;
      check($sformatf("step_state%0d", i), 64'(state), 64'd3);
      check($sformatf("step_cap%0d", i), 64'(dt_cap), (i == 1) ? 64'd0 : dmax32);
      check($sformatf("step_stall%0d", i), 64'(emu_stall), (i == 1) ? 64'd1 : 64'd0);
      check($sformatf("step_done%0d", i), 64'(done), 64'd0);
      tick();
    end
    ext_hold = 1'b0;
    check("step_end_state", 64'(state), 64'd0);
    check("step_end_done",  64'(done), 64'd1);
    check("step_end_stall", 64'(emu_stall), 64'd1);
    check("step_end_time",  64'(emu_time - t0), 64'd21);
    tick();
    check("step_done_clr", 64'(done), 64'd0);

    // Free run, back-pressured RUN, then STOP
    send_cmd(2'd1, 64'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("free_cap%0d", i), 64'(dt_cap), dmax32);
      check($sformatf("free_state%0d", i), 64'(state), 64'd1);
      tick();
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'd1;
    #1;
    check("free_run_ready0", 64'(cmd_if.cmd_ready), 64'd0);
    tick();
    check("free_run_ready1", 64'(cmd_if.cmd_ready), 64'd0);
    check("free_run_state",  64'(state), 64'd1);
    check("free_run_busy",   64'(busy), 64'd1);
    cmd_if.cmd_op = 2'd0;
    #1;
    check("free_stop_ready", 64'(cmd_if.cmd_ready), 64'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("free_stop_state", 64'(state), 64'd0);
    check("free_stop_done",  64'(done), 64'd1);
    check("free_stop_cap",   64'(dt_cap), 64'd0);
    tick();
    check("free_stop_done_clr", 64'(done), 64'd0);

    // Reset during free run aborts with no done
    send_cmd(2'd1, 64'd0);
    tick();
    check("mid_rst_pre", 64'(state), 64'd1);
    #2;
    emu_rst_n = 1'b0;
    #1;
    check("mid_rst_cap",   64'(dt_cap), 64'd0);
    check("mid_rst_state", 64'(state), 64'd0);
    check("mid_rst_busy",  64'(busy), 64'd0);
    tick();
    emu_rst_n = 1'b1;
    check("mid_rst_done0", 64'(done), 64'd0);
    tick();
    check("mid_rst_done1", 64'(done), 64'd0);
    check("mid_rst_state1", 64'(state), 64'd0);

    // 8-bit dt saturates at 127 then lands on target 1000
    check("w8_time0", 64'(emu_time8), 64'd0);
    send_cmd8(2'd2, 64'd1000);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("w8_cap%0d", i), 64'(dt_cap8), (i < 7) ? 64'd127 : 64'd111);
      check($sformatf("w8_state%0d", i), 64'(state8), 64'd2);
      tick();
    end
    check("w8_end_time",  64'(emu_time8), 64'd1000);
    check("w8_end_done",  64'(done8), 64'd1);
    check("w8_end_state", 64'(state8), 64'd0);
    tick();
    check("w8_done_clr", 64'(done8), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
